// File: rtl/vpg_seq_pkg.sv
// Shared types and constants for the video-mode switch sequencer.
// Mode codes mirror the legacy vpg mode defines so callers can keep using names.
package vpg_seq_pkg;

    localparam int MODE_W        = 4;
    localparam int NUM_MODES_DEF = 10;

    localparam logic [MODE_W-1:0] VPG_MODE_640X480_60   = 4'd0;
    localparam logic [MODE_W-1:0] VPG_MODE_800X600_60   = 4'd1;
    localparam logic [MODE_W-1:0] VPG_MODE_1024X768_60  = 4'd2;
    localparam logic [MODE_W-1:0] VPG_MODE_1280X720_60  = 4'd3;
    localparam logic [MODE_W-1:0] VPG_MODE_1280X1024_60 = 4'd4;
    localparam logic [MODE_W-1:0] VPG_MODE_1366X768_60  = 4'd5;
    localparam logic [MODE_W-1:0] VPG_MODE_1600X900_60  = 4'd6;
    localparam logic [MODE_W-1:0] VPG_MODE_1920X1080_30 = 4'd7;
    localparam logic [MODE_W-1:0] VPG_MODE_1920X1080_50 = 4'd8;
    localparam logic [MODE_W-1:0] VPG_MODE_1920X1080_60 = 4'd9;

    typedef enum logic [2:0] {
        INIT,
        BLANK,
        PLL_REQ,
        LOCK_WAIT,
        LOAD,
        SETTLE,
        RUN,
        FAULT
    } seq_state_t;

    function automatic logic mode_valid(input logic [MODE_W-1:0] mode, input int num_modes);
        return int'(mode) < num_modes;
    endfunction

endpackage

// File: rtl/vpg_seq_timer.sv
// Loadable down-counter advancing on clk_en ticks; saturates at zero and
// flags done there, so a load of N-1 spans exactly N ticks.
module vpg_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clk_en,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clk_en) begin
            if (load)
                cnt <= load_val;
            else if (cnt != '0)
                cnt <= cnt - W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/vpg_mode_sequencer.sv
// Video-mode switch sequencer: blanks video, reprograms the pixel PLL with
// lock timeout and retry, reloads the timing generator, then re-enables video.
module vpg_mode_sequencer
    import vpg_seq_pkg::*;
#(
    parameter int BLANK_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRY     = 2,
    parameter int NUM_MODES     = NUM_MODES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clk_en,
    input  logic              vpg_mode_change,
    input  logic [MODE_W-1:0] vpg_mode,
    input  logic              pll_ack,
    input  logic              pll_locked,
    output logic              pll_req,
    output logic [MODE_W-1:0] pll_cfg_sel,
    output logic              timing_load,
    output logic [MODE_W-1:0] timing_mode,
    output logic              video_enable,
    output logic              seq_busy,
    output logic              seq_fault
);
    localparam int DLY_MAX = (BLANK_CYCLES > SETTLE_CYCLES) ? BLANK_CYCLES : SETTLE_CYCLES;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 2);

    localparam logic [DLY_W-1:0] BLANK_LD  = DLY_W'(BLANK_CYCLES - 1);
    localparam logic [DLY_W-1:0] SETTLE_LD = DLY_W'(SETTLE_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LD     = TO_W'(LOCK_TIMEOUT - 1);

    seq_state_t        state, state_nx;
    logic [MODE_W-1:0] target, pending_mode;
    logic              pending;
    logic [RTY_W-1:0]  retry_cnt, retry_inc;
    logic              chg_ok, dly_load, dly_done, to_load, to_done;
    logic [DLY_W-1:0]  dly_val;

    assign chg_ok    = clk_en && vpg_mode_change && mode_valid(vpg_mode, NUM_MODES);
    assign retry_inc = retry_cnt + RTY_W'(1);

    vpg_seq_timer #(.W(DLY_W)) u_dly (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en   (clk_en),
        .load     (dly_load),
        .load_val (dly_val),
        .done     (dly_done)
    );

    vpg_seq_timer #(.W(TO_W)) u_to (
        .clk      (clk),
        .reset_n  (reset_n),
        .clk_en   (clk_en),
        .load     (to_load),
        .load_val (TO_LD),
        .done     (to_done)
    );

    always_comb begin
        state_nx = state;
        dly_load = 1'b0;
        dly_val  = BLANK_LD;
        to_load  = 1'b0;
        case (state)
            INIT: begin
                state_nx = BLANK;
                dly_load = 1'b1;
            end
            BLANK:
                if (dly_done) state_nx = PLL_REQ;
            PLL_REQ:
                if (pll_ack) begin
                    state_nx = LOCK_WAIT;
                    to_load  = 1'b1;
                end
            LOCK_WAIT:
                // lock is checked first so it wins a same-tick timeout
                if (pll_locked)
                    state_nx = LOAD;
                else if (to_done)
                    state_nx = (retry_inc <= RTY_W'(MAX_RETRY)) ? PLL_REQ : FAULT;
            LOAD: begin
                state_nx = SETTLE;
                dly_load = 1'b1;
                dly_val  = SETTLE_LD;
            end
            SETTLE:
                if (dly_done) state_nx = (pending || chg_ok) ? PLL_REQ : RUN;
            RUN, FAULT:
                if (chg_ok) begin
                    state_nx = BLANK;
                    dly_load = 1'b1;
                end
            default:
                state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= INIT;
            target       <= '0;
            pending      <= 1'b0;
            pending_mode <= '0;
            retry_cnt    <= '0;
            timing_mode  <= '0;
        end else if (clk_en) begin
            state <= state_nx;
            case (state)
                INIT: begin
                    // an out-of-range power-up code keeps the reset mode
                    if (mode_valid(vpg_mode, NUM_MODES)) target <= vpg_mode;
                    retry_cnt <= '0;
                end
                LOCK_WAIT:
                    if (!pll_locked && to_done) retry_cnt <= retry_inc;
                SETTLE:
                    if (dly_done && (pending || chg_ok)) begin
                        target    <= chg_ok ? vpg_mode : pending_mode;
                        pending   <= 1'b0;
                        retry_cnt <= '0;
                    end
                RUN, FAULT:
                    if (chg_ok) begin
                        target    <= vpg_mode;
                        retry_cnt <= '0;
                    end
                default: ;
            endcase
            // INIT's own capture already serves a request made on its tick
            if (chg_ok && seq_busy && state != INIT && !(state == SETTLE && dly_done)) begin
                pending      <= 1'b1;
                pending_mode <= vpg_mode;
            end
            if (state_nx == LOAD) timing_mode <= target;
        end
    end

    assign pll_req      = (state == PLL_REQ);
    assign pll_cfg_sel  = target;
    assign timing_load  = (state == LOAD) && clk_en;
    assign video_enable = (state == RUN);
    assign seq_busy     = (state != RUN) && (state != FAULT);
    assign seq_fault    = (state == FAULT);

endmodule
